// File: rtl/ysyx_22040931_dmem_resp_if.sv
// Request/response bus between a load/store requester and the data-memory responder.
interface ysyx_22040931_dmem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wr, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_22040931_dmem_resp.sv
// Single-outstanding 64-bit data memory responder with fixed access latency.
// Optional alignment checking is enabled by defining YSYX_22040931_DMEM_MISALIGN_CHK_EN.
module ysyx_22040931_dmem_resp #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 1,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
    input logic clock,
    input logic reset,
    ysyx_22040931_dmem_resp_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    h_wr;
    logic [1:0]              h_size;
    logic [63:0]             h_addr;
    logic [63:0]             h_wdata;
    logic                    req_ready_q;
    logic                    rsp_valid_q;
    logic [63:0]             rsp_rdata_q;
    logic                    rsp_err_q;
    logic [63:0]             mem [DEPTH];

    logic                    accept_c;
    logic                    done_c;
    logic                    misalign_c;
    logic                    we_c;
    logic [7:0]              mask_c;
    logic [DEPTH_LOG2-1:0]   idx_c;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Word index wraps modulo the array depth; out-of-range addresses alias.
    assign idx_c = DEPTH_LOG2'((h_addr - BASE_ADDR) >> 3);

    // Lane mask; misaligned H/W shift past the word edge and get truncated.
    always_comb begin
        mask_c = 8'h00;
        case (h_size)
            2'b00:   mask_c = 8'(8'h01 << h_addr[2:0]);
            2'b01:   mask_c = 8'(8'h03 << h_addr[2:0]);
            2'b10:   mask_c = 8'(8'h0F << h_addr[2:0]);
            default: mask_c = 8'hFF;
        endcase
    end

`ifdef YSYX_22040931_DMEM_MISALIGN_CHK_EN
    always_comb begin
        misalign_c = 1'b0;
        case (h_size)
            2'b01:   misalign_c = h_addr[0];
            2'b10:   misalign_c = |h_addr[1:0];
            2'b11:   misalign_c = |h_addr[2:0];
            default: misalign_c = 1'b0;
        endcase
    end
`else
    assign misalign_c = 1'b0;
`endif

    // Reset in the final ACCESS cycle still suppresses the write.
    assign we_c = done_c && h_wr && !misalign_c && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        done_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    accept_c = 1'b1;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    done_c  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags, latency counter and response payload.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
            if (accept_c) begin
                cnt_q <= CNT_W'(LATENCY - 1);
            end else if (state_q == ACCESS && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (done_c) begin
                rsp_rdata_q <= (h_wr || misalign_c) ? 64'h0 : mem[idx_c];
                rsp_err_q   <= misalign_c;
            end
        end
    end

    // Request holding registers; only meaningful after an accept.
    always_ff @(posedge clock) begin
        if (accept_c) begin
            h_wr    <= bus.req_wr;
            h_size  <= bus.req_size;
            h_addr  <= bus.req_addr;
            h_wdata <= bus.req_wdata;
        end
    end

    // Storage array is deliberately not reset.
    always_ff @(posedge clock) begin
        if (we_c) begin
            for (int i = 0; i < 8; i++) begin
                if (mask_c[i]) begin
                    mem[idx_c][8*i +: 8] <= h_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule
